// File: rtl/note_voice_alloc_if.sv
// ---------------------------------------------------------------------------
// note_voice_alloc_if
//   Bundle between the keyboard/pedal side and the voice allocator.
//   master : keyboard side, drives key_down/sustain, observes voice state.
//   slave  : allocator side, consumes keys, drives voice state and pulses.
//   Signals:
//     key_down     [511:0]         held-key bitmap by 9-bit scan code
//     sustain                      pedal; high defers releases
//     voice_active [NUM_VOICES-1:0] slot v sounding
//     voice_note   [3*NUM_VOICES-1:0] slot v note in bits [3v+2:3v]
//     note_on / note_off / steal   one-cycle event pulses
//     event_voice  [1:0]           slot of the current pulse, 0 when idle
// ---------------------------------------------------------------------------
interface note_voice_alloc_if #(
    parameter int NUM_VOICES = 4
);
    logic [511:0]              key_down;
    logic                      sustain;
    logic [NUM_VOICES-1:0]     voice_active;
    logic [3*NUM_VOICES-1:0]   voice_note;
    logic                      note_on;
    logic                      note_off;
    logic                      steal;
    logic [1:0]                event_voice;

    modport master (
        output key_down, sustain,
        input  voice_active, voice_note, note_on, note_off, steal, event_voice
    );

    modport slave (
        input  key_down, sustain,
        output voice_active, voice_note, note_on, note_off, steal, event_voice
    );
endinterface

// File: rtl/note_voice_alloc.sv
// ---------------------------------------------------------------------------
// note_voice_alloc
//   Polyphonic voice allocator. Scans the seven note keys round-robin (one
//   note per cycle) and maps each held note to one of NUM_VOICES slots,
//   stealing the oldest slot when all are busy and deferring releases while
//   sustain is held.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  note_voice_alloc_if.slave (keys/pedal in, voice state/pulses out)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module note_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    note_voice_alloc_if.slave    bus
);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef logic [2:0]       note_t;
    typedef logic [AGE_W-1:0] age_t;

    // Scan code of each note key, 0=C4 .. 6=B4.
    function automatic logic [8:0] note_code(input note_t n);
        case (n)
            3'd0:    note_code = 9'h01C;
            3'd1:    note_code = 9'h032;
            3'd2:    note_code = 9'h021;
            3'd3:    note_code = 9'h023;
            3'd4:    note_code = 9'h024;
            3'd5:    note_code = 9'h02B;
            3'd6:    note_code = 9'h034;
            default: note_code = 9'h01C;
        endcase
    endfunction

    note_t                 scan_idx_q, scan_idx_d;
    logic [NUM_VOICES-1:0] voice_active_q, voice_active_d;
    note_t                 voice_note_q [NUM_VOICES];
    note_t                 voice_note_d [NUM_VOICES];
    age_t                  age_q [NUM_VOICES];
    age_t                  age_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] pending_q, pending_d;
    logic                  note_on_q, note_on_d;
    logic                  note_off_q, note_off_d;
    logic                  steal_q, steal_d;
    logic [1:0]            event_voice_q, event_voice_d;

    logic                  held;
    logic                  has_owner;
    logic [1:0]            owner_idx;
    logic                  has_free;
    logic [1:0]            free_idx;
    logic [1:0]            steal_idx;
    age_t                  best_age;
    logic [1:0]            slot;
    logic                  scan_event;
    logic                  has_pend;
    logic [1:0]            pend_idx;

    always_comb begin
        scan_idx_d     = (scan_idx_q == 3'd6) ? 3'd0 : scan_idx_q + 3'd1;
        voice_active_d = voice_active_q;
        pending_d      = pending_q;
        note_on_d      = 1'b0;
        note_off_d     = 1'b0;
        steal_d        = 1'b0;
        event_voice_d  = 2'd0;
        scan_event     = 1'b0;
        slot           = 2'd0;
        has_pend       = 1'b0;
        pend_idx       = 2'd0;

        held = bus.key_down[note_code(scan_idx_q)];

        // Descending loops leave the lowest matching slot selected.
        has_owner = 1'b0;
        owner_idx = 2'd0;
        has_free  = 1'b0;
        free_idx  = 2'd0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (voice_active_q[v] && voice_note_q[v] == scan_idx_q) begin
                has_owner = 1'b1;
                owner_idx = 2'(v);
            end
            if (!voice_active_q[v]) begin
                has_free = 1'b1;
                free_idx = 2'(v);
            end
        end

        // Oldest slot; strict compare keeps the lowest index on ties.
        steal_idx = 2'd0;
        best_age  = age_q[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > best_age) begin
                best_age  = age_q[v];
                steal_idx = 2'(v);
            end
        end

        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_note_d[v] = voice_note_q[v];
            if (voice_active_q[v])
                age_d[v] = (age_q[v] == AGE_MAX) ? age_q[v] : age_q[v] + age_t'(1);
            else
                age_d[v] = '0;
        end

        // Scan step for the note under scan_idx.
        if (held && !has_owner) begin
            if (has_free) begin
                slot = free_idx;
            end else begin
                slot    = steal_idx;
                steal_d = 1'b1;
            end
            voice_note_d[slot]   = scan_idx_q;
            voice_active_d[slot] = 1'b1;
            age_d[slot]          = '0;
            pending_d[slot]      = 1'b0;
            note_on_d            = 1'b1;
            event_voice_d        = slot;
            scan_event           = 1'b1;
        end else if (!held && has_owner) begin
            if (!bus.sustain) begin
                voice_active_d[owner_idx] = 1'b0;
                pending_d[owner_idx]      = 1'b0;
                note_off_d                = 1'b1;
                event_voice_d             = owner_idx;
                scan_event                = 1'b1;
            end else begin
                pending_d[owner_idx] = 1'b1;
            end
        end else if (held && has_owner) begin
            pending_d[owner_idx] = 1'b0;
        end

        // Deferred releases fill cycles where the scan step was silent.
        if (!scan_event && !bus.sustain) begin
            for (int v = NUM_VOICES - 1; v >= 0; v--) begin
                if (pending_d[v]) begin
                    has_pend = 1'b1;
                    pend_idx = 2'(v);
                end
            end
            if (has_pend) begin
                voice_active_d[pend_idx] = 1'b0;
                pending_d[pend_idx]      = 1'b0;
                note_off_d               = 1'b1;
                event_voice_d            = pend_idx;
            end
        end

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!voice_active_d[v])
                age_d[v] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx_q     <= '0;
            voice_active_q <= '0;
            pending_q      <= '0;
            note_on_q      <= 1'b0;
            note_off_q     <= 1'b0;
            steal_q        <= 1'b0;
            event_voice_q  <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_note_q[v] <= '0;
                age_q[v]        <= '0;
            end
        end else begin
            scan_idx_q     <= scan_idx_d;
            voice_active_q <= voice_active_d;
            pending_q      <= pending_d;
            note_on_q      <= note_on_d;
            note_off_q     <= note_off_d;
            steal_q        <= steal_d;
            event_voice_q  <= event_voice_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_note_q[v] <= voice_note_d[v];
                age_q[v]        <= age_d[v];
            end
        end
    end

    assign bus.voice_active = voice_active_q;
    assign bus.note_on      = note_on_q;
    assign bus.note_off     = note_off_q;
    assign bus.steal        = steal_q;
    assign bus.event_voice  = event_voice_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note_out
        assign bus.voice_note[3*g +: 3] = voice_note_q[g];
    end
endmodule

// File: tb/tb_note_voice_alloc.sv
// ---------------------------------------------------------------------------
// tb_note_voice_alloc
//   Directed bench: a table of 7-cycle-aligned phases (held notes, sustain,
//   expected voice state and pulse counts), plus hand sequences for reset,
//   first-scan latency and mid-operation reset. Non-note key bits carry
//   random noise that must be ignored.
// ---------------------------------------------------------------------------
module tb_note_voice_alloc;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    note_voice_alloc_if #(.NUM_VOICES(4)) bus ();

    note_voice_alloc #(.NUM_VOICES(4), .AGE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [6:0]  mask;
        logic        sus;
        int          cycles;
        logic [3:0]  exp_act;
        logic [11:0] exp_notes;
        int          exp_on;
        int          exp_off;
        int          exp_steal;
        int          exp_ev;     // event_voice of last pulse, -1 = no pulse
        logic        first_off;  // note_off expected on first cycle
    } vec_t;

    vec_t tbl [15];

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] cur_mask = '0;
    logic       cur_sus  = 1'b0;

    int cnt_on, cnt_off, cnt_steal, last_ev, idle_bad;
    logic first_off_seen;

    function automatic logic [8:0] tb_code(input int n);
        case (n)
            0: return 9'h01C;
            1: return 9'h032;
            2: return 9'h021;
            3: return 9'h023;
            4: return 9'h024;
            5: return 9'h02B;
            default: return 9'h034;
        endcase
    endfunction

    function automatic vec_t mk(input logic [6:0] mask, input logic sus, input int cycles,
                                input logic [3:0] act, input logic [11:0] notes,
                                input int on, input int off, input int stl,
                                input int ev, input logic fo);
        vec_t r;
        r.mask = mask; r.sus = sus; r.cycles = cycles; r.exp_act = act;
        r.exp_notes = notes; r.exp_on = on; r.exp_off = off; r.exp_steal = stl;
        r.exp_ev = ev; r.first_off = fo;
        return r;
    endfunction

    function automatic logic [11:0] act_mask(input logic [3:0] act);
        logic [11:0] m;
        for (int v = 0; v < 4; v++) m[3*v +: 3] = act[v] ? 3'b111 : 3'b000;
        return m;
    endfunction

    // Drive keys from cur_mask with fresh noise on every non-note bit.
    task automatic drive();
        logic [511:0] kd;
        for (int w = 0; w < 16; w++) kd[32*w +: 32] = $urandom;
        for (int n = 0; n < 7; n++) kd[tb_code(n)] = cur_mask[n];
        bus.key_down = kd;
        bus.sustain  = cur_sus;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One clock: sample 1 time unit after the edge, then re-drive inputs.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.note_on)  cnt_on++;
        if (bus.note_off) cnt_off++;
        if (bus.steal)    cnt_steal++;
        if (bus.note_on || bus.note_off) last_ev = int'(bus.event_voice);
        else if (bus.event_voice != 2'd0) idle_bad++;
        drive();
    endtask

    task automatic clr_counts();
        cnt_on = 0; cnt_off = 0; cnt_steal = 0; last_ev = -1; idle_bad = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_active"}, 32'(bus.voice_active), 32'd0);
        check({tag, "_notes"},  32'(bus.voice_note),   32'd0);
        check({tag, "_pulses"}, {29'd0, bus.note_on, bus.note_off, bus.steal}, 32'd0);
        check({tag, "_ev"},     32'(bus.event_voice),  32'd0);
    endtask

    initial begin
        bool_wait_ok: begin end
    end

    initial begin
        bit seen;
        // Phases are multiples of 7 cycles, so each starts at scan_idx 0.
        tbl[0]  = mk(7'b0010101, 0,  7, 4'b0111, {3'd0, 3'd4, 3'd2, 3'd0}, 3, 0, 0,  2, 0);
        tbl[1]  = mk(7'b0000000, 0,  7, 4'b0000, 12'd0,                    0, 3, 0,  2, 0);
        tbl[2]  = mk(7'b0001111, 0,  7, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4, 0, 0,  3, 0);
        tbl[3]  = mk(7'b0001111, 0, 14, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 0, 0, 0, -1, 0);
        tbl[4]  = mk(7'b1001111, 0,  7, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd6}, 1, 0, 1,  0, 0);
        tbl[5]  = mk(7'b1001110, 0,  7, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd6}, 0, 0, 0, -1, 0);
        tbl[6]  = mk(7'b0000000, 0,  7, 4'b0000, 12'd0,                    0, 4, 0,  0, 0);
        tbl[7]  = mk(7'b0100000, 1,  7, 4'b0001, {9'd0, 3'd5},             1, 0, 0,  0, 0);
        tbl[8]  = mk(7'b0000000, 1,  7, 4'b0001, {9'd0, 3'd5},             0, 0, 0, -1, 0);
        tbl[9]  = mk(7'b0000000, 0,  7, 4'b0000, 12'd0,                    0, 1, 0,  0, 1);
        tbl[10] = mk(7'b0010000, 1,  7, 4'b0001, {9'd0, 3'd4},             1, 0, 0,  0, 0);
        tbl[11] = mk(7'b0000000, 1,  7, 4'b0001, {9'd0, 3'd4},             0, 0, 0, -1, 0);
        tbl[12] = mk(7'b0010000, 1,  7, 4'b0001, {9'd0, 3'd4},             0, 0, 0, -1, 0);
        tbl[13] = mk(7'b0010000, 0,  7, 4'b0001, {9'd0, 3'd4},             0, 0, 0, -1, 0);
        tbl[14] = mk(7'b0000000, 0,  7, 4'b0000, 12'd0,                    0, 1, 0,  0, 0);

        // Reset state with C4 already held.
        cur_mask = 7'b0000001;
        cur_sus  = 1'b0;
        drive();
        clr_counts();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");

        // First scan cycle after reset evaluates C4.
        rst = 1'b0;
        step();
        check("first_note_on", 32'(bus.note_on), 32'd1);
        check("first_ev", 32'(bus.event_voice), 32'd0);
        check("first_active", 32'(bus.voice_active), 32'h1);
        check("first_note", 32'(bus.voice_note[2:0]), 32'd0);

        // Release: note_off must appear within one sweep.
        cur_mask = '0;
        drive();
        seen = 1'b0;
        for (int i = 0; i < 7 && !seen; i++) begin
            step();
            if (bus.note_off) begin
                seen = 1'b1;
                check("single_off_ev", 32'(bus.event_voice), 32'd0);
            end
        end
        check("single_off_seen", 32'(seen), 32'd1);
        check("single_off_active", 32'(bus.voice_active), 32'd0);

        // Realign scan to 0.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int r = 0; r < 15; r++) begin
            cur_mask = tbl[r].mask;
            cur_sus  = tbl[r].sus;
            drive();
            clr_counts();
            first_off_seen = 1'b0;
            for (int c = 0; c < tbl[r].cycles; c++) begin
                step();
                if (c == 0) first_off_seen = bus.note_off;
            end
            check($sformatf("row%0d_active", r), 32'(bus.voice_active), 32'(tbl[r].exp_act));
            check($sformatf("row%0d_notes", r), 32'(bus.voice_note & act_mask(tbl[r].exp_act)),
                  32'(tbl[r].exp_notes));
            check($sformatf("row%0d_on", r), 32'(cnt_on), 32'(tbl[r].exp_on));
            check($sformatf("row%0d_off", r), 32'(cnt_off), 32'(tbl[r].exp_off));
            check($sformatf("row%0d_steal", r), 32'(cnt_steal), 32'(tbl[r].exp_steal));
            check($sformatf("row%0d_last_ev", r), 32'(last_ev), 32'(tbl[r].exp_ev));
            check($sformatf("row%0d_idle_ev", r), 32'(idle_bad), 32'd0);
            if (tbl[r].first_off)
                check($sformatf("row%0d_first_off", r), 32'(first_off_seen), 32'd1);
        end

        // Mid-operation reset: three voices, reset off-sweep, keys stay held.
        cur_mask = 7'b0101010;
        cur_sus  = 1'b0;
        drive();
        clr_counts();
        repeat (7) step();
        check("mid_pre_active", 32'(bus.voice_active), 32'h7);
        check("mid_pre_notes", 32'(bus.voice_note[8:0]), 32'({3'd5, 3'd3, 3'd1}));
        repeat (3) step();
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr_counts();
        repeat (7) step();
        check("mid_post_on", 32'(cnt_on), 32'd3);
        check("mid_post_active", 32'(bus.voice_active), 32'h7);
        check("mid_post_notes", 32'(bus.voice_note[8:0]), 32'({3'd5, 3'd3, 3'd1}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound in case the stimulus process stalls.
    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, %0d vectors applied", n_vec);
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end
endmodule

// File: doc/note_voice_alloc.md
Name: note_voice_alloc

Overview:
Polyphonic voice allocator between the keyboard key_down bitmap and the per-voice tone oscillators. It scans the seven note keys round-robin and assigns each held note to one of NUM_VOICES voice slots. When all slots are busy it steals the oldest voice, and it defers releases while sustain is held. The outputs drive the oscillator bank (note index per voice) and the mixer (active mask).

Parameters:
NUM_VOICES, 4, number of voice slots (legal range 2..4)
AGE_W, 8, width of per-voice age counter (saturating)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
key_down  input  512  held-key bitmap indexed by 9-bit scan code
sustain  input  1  sustain pedal; high defers all releases
voice_active  output  NUM_VOICES  bit v = slot v sounding
voice_note  output  3*NUM_VOICES  slot v note index in bits [3v+2:3v]; 0=C4 … 6=B4
note_on  output  1  one-cycle pulse: slot allocated or stolen this cycle
note_off  output  1  one-cycle pulse: slot released this cycle
steal  output  1  one-cycle pulse, coincident with note_on, when allocation evicted a sounding note
event_voice  output  2  slot index for the current note_on/note_off pulse; 0 when no pulse

Behaviour:
- Reset (async, immediate): voice_active=0, voice_note=0, all ages=0, scan_idx=0, all pulses=0, event_voice=0, all pending_release=0.
- Note key map. Scan code → note index: 0x01C→0, 0x032→1, 0x021→2, 0x023→3, 0x024→4, 0x02B→5, 0x034→6. All other key_down bits are ignored.
- scan_idx: 3-bit counter, 0..6, +1 per cycle, wraps 6→0. One note is evaluated per cycle, so a full sweep takes 7 cycles.
- Per cycle, for n = scan_idx, with held = key_down[code(n)] and owner = lowest slot v where voice_active[v] and voice_note[v]==n:
  - held, no owner, a free slot exists: allocate the lowest free slot f. Set voice_note[f]=n, set active, clear age. Pulse note_on with event_voice=f.
  - held, no owner, no free slot: steal slot s with maximum age (tie → lowest index). Overwrite voice_note[s]=n, clear age. Pulse note_on and steal with event_voice=s.
  - not held, owner exists, sustain=0: clear voice_active[owner]. Pulse note_off with event_voice=owner.
  - not held, owner exists, sustain=1: set pending_release[owner]; no pulse.
  - held, owner exists: clear pending_release[owner] (note re-pressed under sustain); no pulse.
- Sustain release: evaluated only in cycles where the scan step produced no event. If sustain=0 and any pending_release bit is set, release the lowest such slot and clear its bit. Pulse note_off with event_voice set to that slot. At most one note_off per cycle.
- Event rate: at most one event (note_on or note_off) per cycle; the scan step has priority over pending releases.
- Latency: registered outputs. Key press to voice_active/note_on takes 1 to 7 cycles, depending on scan_idx at the time of the press.
- Ages: each active slot's age increments by 1 per cycle, saturating at 2^AGE_W-1. Inactive slots hold age 0. An allocated or stolen slot's age reads 0 in the cycle after the event.
- Duplicate notes are impossible by construction: allocation only occurs when no owner exists.
- A stolen slot clears its pending_release bit.
- Inactive slots keep their last voice_note value; consumers must gate on voice_active.

Test Plan:
- Reset mid-operation: 3 voices active, assert rst for 1 cycle → all outputs 0 in the same cycle; after release, scan_idx restarts at 0 and the still-held keys re-allocate to slots 0,1,2 in note-index order.
- Single note: hold key 0x01C from reset → note_on with event_voice=0 on the first scan cycle; voice_note[2:0]=0, voice_active=4'b0001. Release → note_off within 7 cycles, voice_active=0.
- Chord fill: hold 0x01C, 0x021, 0x024 together → slots 0,1,2 active with notes 0,2,4, three note_on pulses on distinct cycles inside one 7-cycle sweep.
- Steal: hold C4, D4, E4, F4 (all 4 slots), wait 20 cycles, then press B4 → steal with event_voice=0 (the oldest slot, C4). Slot 0 note becomes 6; the later C4 release produces no note_off.
- Sustain: sustain=1, press then release A4 → voice stays active with no note_off. Drop sustain → note_off for that slot the next cycle, provided the scan step has no event.
- Re-press under sustain: sustain=1, press, release, re-press G4, then drop sustain → voice remains active and no note_off is emitted.
